// File: rtl/sat_swarm_node_if.sv
// sat_swarm_node_if
//   Bundles the clause-memory read port and the two fork handshakes of a
//   swarm node so a mesh tile can wire a node with a single connection.
//
//   clause_addr     clause read address (node -> memory)
//   clause_rd_data  clause word, one cycle after clause_addr (memory -> node)
//   fork_in_*       incoming work offer: valid/assign in, ready out of node
//   fork_out_*      alternate-branch offer: valid/sel/assign out of node,
//                   one ready bit per neighbour into the node
//
//   Modports: master = the node side, slave = the memory/mesh side.
interface sat_swarm_node_if #(
  parameter int NUM_VARS      = 16,
  parameter int VAR_WIDTH     = 4,
  parameter int CLAUSE_LENGTH = 3,
  parameter int NUM_CLAUSES   = 16,
  parameter int NUM_NEIGHBORS = 4
);
  localparam int LIT_W = VAR_WIDTH + 2;
  localparam int CAW   = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;

  logic [CAW-1:0]                   clause_addr;
  logic [CLAUSE_LENGTH*LIT_W-1:0]   clause_rd_data;
  logic                             fork_in_valid;
  logic                             fork_in_ready;
  logic [2*NUM_VARS-1:0]            fork_in_assign;
  logic                             fork_out_valid;
  logic [NUM_NEIGHBORS-1:0]         fork_out_ready;
  logic [NUM_NEIGHBORS-1:0]         fork_out_sel;
  logic [2*NUM_VARS-1:0]            fork_out_assign;

  modport master (
    output clause_addr,
    input  clause_rd_data,
    input  fork_in_valid,
    output fork_in_ready,
    input  fork_in_assign,
    output fork_out_valid,
    input  fork_out_ready,
    output fork_out_sel,
    output fork_out_assign
  );

  modport slave (
    input  clause_addr,
    output clause_rd_data,
    output fork_in_valid,
    input  fork_in_ready,
    output fork_in_assign,
    input  fork_out_valid,
    output fork_out_ready,
    input  fork_out_sel,
    input  fork_out_assign
  );
endinterface

// File: rtl/sat_swarm_node.sv
// sat_swarm_node
//   One DPLL worker of the SAT swarm mesh. It accepts a partial assignment,
//   streams the formula from external clause memory in evaluation passes,
//   applies unit implications, decides on the lowest unassigned variable and
//   hands the alternate branch to an idle neighbour or to a local snapshot
//   stack. Conflicts backtrack chronologically from that stack.
//
//   clk, rst     clock and synchronous active-high reset
//   abort        global stop: back to IDLE, stack emptied
//   bus          sat_swarm_node_if.master (clause port, fork in/out)
//   busy         node is not IDLE
//   sat_found    sticky until rst: a satisfying assignment is held
//   sat_assign   that assignment (zero while sat_found is low)
//   exhausted    one-cycle pulse: subtree refuted with an empty stack
//
//   Assignment packing: variable i lives in bits [2i+1:2i];
//   00/11 unassigned, 01 true, 10 false.
module sat_swarm_node #(
  parameter int NUM_VARS      = 16,
  parameter int VAR_WIDTH     = 4,
  parameter int CLAUSE_LENGTH = 3,
  parameter int NUM_CLAUSES   = 16,
  parameter int NUM_NEIGHBORS = 4,
  parameter int STACK_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  sat_swarm_node_if.master      bus,
  output logic                  busy,
  output logic                  sat_found,
  output logic [2*NUM_VARS-1:0] sat_assign,
  output logic                  exhausted
);
  localparam int LIT_W = VAR_WIDTH + 2;
  localparam int CAW   = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int CNTW  = $clog2(NUM_CLAUSES + 1);
  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam int SIW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int OCW   = $clog2(CLAUSE_LENGTH + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EVAL      = 3'd1;
  localparam logic [2:0] S_DECIDE    = 3'd2;
  localparam logic [2:0] S_FORK      = 3'd3;
  localparam logic [2:0] S_BACKTRACK = 3'd4;
  localparam logic [2:0] S_SAT       = 3'd5;

  logic [2:0]            state;
  logic [2*NUM_VARS-1:0] assign_q;
  logic [2*NUM_VARS-1:0] alt_q;
  logic [CNTW-1:0]       cnt;
  logic                  all_sat;
  logic                  unit_valid;
  logic [VAR_WIDTH-1:0]  unit_var;
  logic                  unit_neg;
  logic [SPW-1:0]        sp;
  logic [SPW-1:0]        sp_dec;
  logic [2*NUM_VARS-1:0] stack_mem [STACK_DEPTH];

  logic [LIT_W-1:0]      lit;
  logic [1:0]            lit_val;
  logic [OCW-1:0]        n_open;
  logic                  any_true;
  logic [VAR_WIDTH-1:0]  open_var;
  logic                  open_neg;
  logic                  cls_sat;
  logic                  cls_conflict;
  logic                  cls_unit;
  logic                  eval_valid;
  logic                  pass_end;
  logic [VAR_WIDTH-1:0]  fin_var;
  logic                  fin_neg;
  logic                  dec_found;
  logic [VAR_WIDTH-1:0]  dec_var;
  logic                  any_ready;
  logic [NUM_NEIGHBORS-1:0] lowest_ready;
  logic                  push;

  // Variable indices beyond NUM_VARS read as unassigned.
  function automatic logic [1:0] var_value(input logic [2*NUM_VARS-1:0] a,
                                           input logic [VAR_WIDTH-1:0] v);
    logic [1:0] r;
    r = 2'b00;
    for (int k = 0; k < NUM_VARS; k++)
      if (int'(v) == k) r = a[2*k +: 2];
    return r;
  endfunction

  function automatic logic [2*NUM_VARS-1:0] set_var(input logic [2*NUM_VARS-1:0] a,
                                                    input logic [VAR_WIDTH-1:0] v,
                                                    input logic [1:0] val);
    logic [2*NUM_VARS-1:0] r;
    r = a;
    for (int k = 0; k < NUM_VARS; k++)
      if (int'(v) == k) r[2*k +: 2] = val;
    return r;
  endfunction

  // Classify the clause word returned for the previous address against the
  // current assignment; the assignment never changes inside a pass.
  always_comb begin
    lit      = '0;
    lit_val  = 2'b00;
    n_open   = '0;
    any_true = 1'b0;
    open_var = '0;
    open_neg = 1'b0;
    for (int i = 0; i < CLAUSE_LENGTH; i++) begin
      lit     = bus.clause_rd_data[i*LIT_W +: LIT_W];
      lit_val = var_value(assign_q, lit[VAR_WIDTH-1:0]);
      if (lit[LIT_W-1]) begin
        if ((lit_val == 2'b01 && !lit[LIT_W-2]) || (lit_val == 2'b10 && lit[LIT_W-2])) begin
          any_true = 1'b1;
        end else if (lit_val == 2'b00 || lit_val == 2'b11) begin
          n_open   = n_open + OCW'(1);
          open_var = lit[VAR_WIDTH-1:0];
          open_neg = lit[LIT_W-2];
        end
      end
    end
    cls_sat      = any_true;
    cls_conflict = !any_true && (n_open == '0);
    cls_unit     = !any_true && (n_open == OCW'(1));
  end

  // Lowest-index unassigned variable for the next decision.
  always_comb begin
    dec_found = 1'b0;
    dec_var   = '0;
    for (int k = NUM_VARS - 1; k >= 0; k--) begin
      if (assign_q[2*k +: 2] == 2'b00 || assign_q[2*k +: 2] == 2'b11) begin
        dec_found = 1'b1;
        dec_var   = VAR_WIDTH'(k);
      end
    end
  end

  assign eval_valid   = (cnt != '0);
  assign pass_end     = (int'(cnt) == NUM_CLAUSES);
  assign fin_var      = unit_valid ? unit_var : open_var;
  assign fin_neg      = unit_valid ? unit_neg : open_neg;
  assign sp_dec       = sp - SPW'(1);
  assign any_ready    = |bus.fork_out_ready;
  assign lowest_ready = bus.fork_out_ready & (~bus.fork_out_ready + NUM_NEIGHBORS'(1));
  assign push         = !rst && !abort && (state == S_FORK) && !any_ready &&
                        (int'(sp) < STACK_DEPTH);

  assign busy               = (state != S_IDLE);
  assign bus.fork_in_ready  = (state == S_IDLE) && !sat_found && !rst && !abort;
  assign bus.fork_out_valid = (state == S_FORK) && !rst && !abort;
  assign bus.fork_out_sel   = bus.fork_out_valid ? lowest_ready : '0;
  assign bus.fork_out_assign = (state == S_FORK) ? alt_q : '0;
  assign bus.clause_addr    = (state == S_EVAL && !pass_end) ? cnt[CAW-1:0] : '0;
  assign sat_assign         = sat_found ? assign_q : '0;
  assign exhausted          = (state == S_BACKTRACK) && (sp == '0) && !rst && !abort;

  // Snapshot storage carries no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp[SIW-1:0]] <= alt_q;
  end

  // Main controller. Every entry into EVAL starts a fresh pass with the
  // unit flag cleared; abort empties the stack but keeps sat_found.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      assign_q   <= '0;
      alt_q      <= '0;
      cnt        <= '0;
      all_sat    <= 1'b0;
      unit_valid <= 1'b0;
      unit_var   <= '0;
      unit_neg   <= 1'b0;
      sp         <= '0;
      sat_found  <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      cnt        <= '0;
      unit_valid <= 1'b0;
      sp         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.fork_in_valid && bus.fork_in_ready) begin
            assign_q   <= bus.fork_in_assign;
            cnt        <= '0;
            all_sat    <= 1'b1;
            unit_valid <= 1'b0;
            state      <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (eval_valid && cls_conflict) begin
            state <= S_BACKTRACK;
          end else if (pass_end) begin
            if (all_sat && cls_sat) begin
              state     <= S_SAT;
              sat_found <= 1'b1;
            end else if (unit_valid || cls_unit) begin
              assign_q   <= set_var(assign_q, fin_var, fin_neg ? 2'b10 : 2'b01);
              cnt        <= '0;
              all_sat    <= 1'b1;
              unit_valid <= 1'b0;
            end else begin
              state <= S_DECIDE;
            end
          end else begin
            cnt <= cnt + CNTW'(1);
            if (eval_valid) begin
              all_sat <= all_sat && cls_sat;
              if (!unit_valid && cls_unit) begin
                unit_valid <= 1'b1;
                unit_var   <= open_var;
                unit_neg   <= open_neg;
              end
            end
          end
        end
        S_DECIDE: begin
          // A fully assigned vector that is neither SAT nor conflicting can
          // only come from malformed clauses; treat it as a dead branch.
          if (dec_found) begin
            assign_q <= set_var(assign_q, dec_var, 2'b01);
            alt_q    <= set_var(assign_q, dec_var, 2'b10);
            state    <= S_FORK;
          end else begin
            state <= S_BACKTRACK;
          end
        end
        S_FORK: begin
          if (any_ready || push) begin
            if (push) sp <= sp + SPW'(1);
            cnt        <= '0;
            all_sat    <= 1'b1;
            unit_valid <= 1'b0;
            state      <= S_EVAL;
          end
        end
        S_BACKTRACK: begin
          if (sp != '0) begin
            assign_q   <= stack_mem[sp_dec[SIW-1:0]];
            sp         <= sp_dec;
            cnt        <= '0;
            all_sat    <= 1'b1;
            unit_valid <= 1'b0;
            state      <= S_EVAL;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SAT: state <= S_SAT;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sat_swarm_node.sv
// tb_sat_swarm_node
//   Directed bench for sat_swarm_node with a 1-cycle clause memory model.
//   A vector table drives whole offers and compares the outcome; hand-written
//   sequences cover the full-stack stall, abort in SAT and abort mid-EVAL.
module tb_sat_swarm_node;
  localparam int NV = 16;
  localparam int VW = 4;
  localparam int CL = 4;
  localparam int NC = 16;
  localparam int NN = 4;
  localparam int SD = 2;
  localparam int LW = VW + 2;

  logic              clk;
  logic              rst;
  logic              abort;
  logic              busy;
  logic              sat_found;
  logic [2*NV-1:0]   sat_assign;
  logic              exhausted;
  logic [CL*LW-1:0]  mem [NC];

  int checks = 0;
  int errors = 0;

  logic        res_sat;
  logic [31:0] res_assign;
  int          res_forks;
  logic [3:0]  res_sel;
  logic [31:0] res_fassign;
  int          res_exh;
  int          res_cycles;
  logic        res_timeout;

  typedef struct {
    string       name;
    int          formula;
    logic [31:0] init;
    logic [3:0]  ready;
    logic        exp_sat;
    logic [31:0] exp_assign;
    int          exp_forks;
    logic [3:0]  exp_sel;
    logic [31:0] exp_fassign;
    int          exp_exh;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [6];

  sat_swarm_node_if #(.NUM_VARS(NV), .VAR_WIDTH(VW), .CLAUSE_LENGTH(CL),
                      .NUM_CLAUSES(NC), .NUM_NEIGHBORS(NN)) bus ();

  sat_swarm_node #(.NUM_VARS(NV), .VAR_WIDTH(VW), .CLAUSE_LENGTH(CL),
                   .NUM_CLAUSES(NC), .NUM_NEIGHBORS(NN), .STACK_DEPTH(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .sat_found  (sat_found),
    .sat_assign (sat_assign),
    .exhausted  (exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clause memory answers one cycle after the address.
  always_ff @(posedge clk) bus.clause_rd_data <= mem[bus.clause_addr];

  function automatic logic [LW-1:0] lit(input logic neg, input int v);
    return {1'b1, neg, VW'(v)};
  endfunction

  function automatic logic [CL*LW-1:0] mk(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                          input logic [LW-1:0] c, input logic [LW-1:0] d);
    return {d, c, b, a};
  endfunction

  // Formulas: 0 (x0|x1)(!x0); 1 (x0)(!x0); 2 (x0|x1|x2); 3 (x0);
  // 4 (!x0|!x1|!x2|x3). Unused slots hold the tautology (x0|!x0).
  task automatic loadFormula(input int f);
    for (int k = 0; k < NC; k++) mem[k] = mk(lit(1'b0, 0), lit(1'b1, 0), '0, '0);
    case (f)
      0: begin
        mem[0] = mk(lit(1'b0, 0), lit(1'b0, 1), '0, '0);
        mem[1] = mk(lit(1'b1, 0), '0, '0, '0);
      end
      1: begin
        mem[0] = mk(lit(1'b0, 0), '0, '0, '0);
        mem[1] = mk(lit(1'b1, 0), '0, '0, '0);
      end
      2: mem[0] = mk(lit(1'b0, 0), lit(1'b0, 1), lit(1'b0, 2), '0);
      3: mem[0] = mk(lit(1'b0, 0), '0, '0, '0);
      default: mem[0] = mk(lit(1'b1, 0), lit(1'b1, 1), lit(1'b1, 2), lit(1'b0, 3));
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    abort = 1'b0;
    bus.fork_in_valid = 1'b0;
    bus.fork_in_assign = '0;
    bus.fork_out_ready = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one assignment and follow the node until SAT or back in IDLE.
  task automatic applyStimulus(input logic [31:0] init, input logic [3:0] ready);
    bus.fork_out_ready = ready;
    bus.fork_in_assign = init;
    bus.fork_in_valid  = 1'b1;
    @(negedge clk);
    bus.fork_in_valid  = 1'b0;
    res_forks   = 0;
    res_sel     = '0;
    res_fassign = '0;
    res_exh     = 0;
    res_cycles  = 0;
    res_timeout = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (sat_found || !busy) begin
        res_timeout = 1'b0;
        break;
      end
      res_cycles++;
      if (bus.fork_out_valid) begin
        if (res_forks == 0) begin
          res_sel     = bus.fork_out_sel;
          res_fassign = bus.fork_out_assign;
        end
        res_forks++;
      end
      if (exhausted) res_exh++;
      @(negedge clk);
    end
    res_sat    = sat_found;
    res_assign = sat_assign;
    bus.fork_out_ready = '0;
  endtask

  initial begin
    int episodes;
    int lens [3];
    int stall_ok;
    int c;
    logic prev;

    vecs[0] = '{"two_units",    0, 32'h0, 4'h0, 1'b1, 32'h6, 0, 4'h0, 32'h0, 0, 51};
    vecs[1] = '{"unit_conflict",1, 32'h0, 4'h0, 1'b0, 32'h0, 0, 4'h0, 32'h0, 1, 21};
    vecs[2] = '{"fork_nbr2",    2, 32'h0, 4'h4, 1'b1, 32'h1, 1, 4'h4, 32'h2, 0, 36};
    vecs[3] = '{"fork_lowest",  2, 32'h0, 4'ha, 1'b1, 32'h1, 1, 4'h2, 32'h2, 0, 36};
    vecs[4] = '{"enc11_unassg", 3, 32'h3, 4'h0, 1'b1, 32'h1, 0, 4'h0, 32'h0, 0, 34};
    vecs[5] = '{"init_confl",   3, 32'h2, 4'h0, 1'b0, 32'h0, 0, 4'h0, 32'h0, 1, 3};

    // Reset values, then ready rises as soon as rst drops.
    loadFormula(0);
    rst = 1'b1;
    abort = 1'b0;
    bus.fork_in_valid = 1'b0;
    bus.fork_in_assign = '0;
    bus.fork_out_ready = 4'hf;
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_sat_found", {31'b0, sat_found}, 0);
    checkOutput("rst_sat_assign", sat_assign, 0);
    checkOutput("rst_exhausted", {31'b0, exhausted}, 0);
    checkOutput("rst_in_ready", {31'b0, bus.fork_in_ready}, 0);
    checkOutput("rst_out_valid", {31'b0, bus.fork_out_valid}, 0);
    checkOutput("rst_out_sel", {28'b0, bus.fork_out_sel}, 0);
    checkOutput("rst_clause_addr", {28'b0, bus.clause_addr}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.fork_out_ready = '0;
    #1;
    checkOutput("post_rst_in_ready", {31'b0, bus.fork_in_ready}, 1);
    checkOutput("post_rst_busy", {31'b0, busy}, 0);

    for (int i = 0; i < 6; i++) begin
      applyReset();
      loadFormula(vecs[i].formula);
      applyStimulus(vecs[i].init, vecs[i].ready);
      checkOutput({vecs[i].name, "_done"}, {31'b0, res_timeout}, 0);
      checkOutput({vecs[i].name, "_sat"}, {31'b0, res_sat}, {31'b0, vecs[i].exp_sat});
      checkOutput({vecs[i].name, "_assign"}, res_assign, vecs[i].exp_assign);
      checkOutput({vecs[i].name, "_forks"}, res_forks, vecs[i].exp_forks);
      checkOutput({vecs[i].name, "_exh"}, res_exh, vecs[i].exp_exh);
      checkOutput({vecs[i].name, "_cycles"}, res_cycles, vecs[i].exp_cycles);
      if (vecs[i].exp_forks > 0) begin
        checkOutput({vecs[i].name, "_sel"}, {28'b0, res_sel}, {28'b0, vecs[i].exp_sel});
        checkOutput({vecs[i].name, "_fassign"}, res_fassign, vecs[i].exp_fassign);
      end
    end

    // Abort while in SAT: back to IDLE, solution stays sticky, no new work.
    applyReset();
    loadFormula(0);
    applyStimulus(32'h0, 4'h0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checkOutput("satabort_busy", {31'b0, busy}, 0);
    checkOutput("satabort_found", {31'b0, sat_found}, 1);
    checkOutput("satabort_assign", sat_assign, 32'h6);
    checkOutput("satabort_in_ready", {31'b0, bus.fork_in_ready}, 0);

    // Two pushes fill the stack; the third decision stalls until a ready.
    applyReset();
    loadFormula(4);
    bus.fork_in_assign = '0;
    bus.fork_in_valid = 1'b1;
    @(negedge clk);
    bus.fork_in_valid = 1'b0;
    episodes = 0;
    lens = '{0, 0, 0};
    prev = 1'b0;
    c = 0;
    while (episodes < 3 && c < 500) begin
      if (bus.fork_out_valid && !prev) episodes++;
      if (bus.fork_out_valid && episodes > 0 && episodes < 3) lens[episodes-1]++;
      prev = bus.fork_out_valid;
      if (episodes < 3) begin
        @(negedge clk);
        c++;
      end
    end
    checkOutput("stall_reached", episodes, 3);
    checkOutput("push1_len", lens[0], 1);
    checkOutput("push2_len", lens[1], 1);
    stall_ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fork_out_valid && bus.fork_out_assign == 32'h25) stall_ok++;
      @(negedge clk);
    end
    checkOutput("stall_cycles", stall_ok, 10);
    bus.fork_out_ready = 4'b0010;
    #1;
    checkOutput("stall_valid", {31'b0, bus.fork_out_valid}, 1);
    checkOutput("stall_sel", {28'b0, bus.fork_out_sel}, 4'b0010);
    @(negedge clk);
    bus.fork_out_ready = '0;
    checkOutput("stall_released", {31'b0, bus.fork_out_valid}, 0);
    c = 0;
    while (!sat_found && c < 500) begin
      @(negedge clk);
      c++;
    end
    checkOutput("stall_sat", {31'b0, sat_found}, 1);
    checkOutput("stall_assign", sat_assign, 32'h55);

    // Abort mid-EVAL after two pushes; the stack must come back empty.
    applyReset();
    loadFormula(4);
    bus.fork_in_assign = '0;
    bus.fork_in_valid = 1'b1;
    @(negedge clk);
    bus.fork_in_valid = 1'b0;
    episodes = 0;
    prev = 1'b0;
    c = 0;
    while (!(episodes == 2 && !bus.fork_out_valid) && c < 500) begin
      @(negedge clk);
      if (bus.fork_out_valid && !prev) episodes++;
      prev = bus.fork_out_valid;
      c++;
    end
    checkOutput("abort_pushes", episodes, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 0);
    checkOutput("abort_in_ready", {31'b0, bus.fork_in_ready}, 1);
    checkOutput("abort_out_valid", {31'b0, bus.fork_out_valid}, 0);
    loadFormula(1);
    applyStimulus(32'h0, 4'h0);
    checkOutput("abort_re_done", {31'b0, res_timeout}, 0);
    checkOutput("abort_re_exh", res_exh, 1);
    checkOutput("abort_re_sat", {31'b0, res_sat}, 0);
    checkOutput("abort_re_cycles", res_cycles, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
